alu_op_controller: RTL and testbench

- Multi-cycle control FSM that sequences the 8-bit ALU (SELECT: 000 forward, 001 add, 010 and, 011 or) and the 8x8 register file.
- Accepts one 32-bit instruction at a time over a valid/ready handshake and decodes it.
- Drives register read addresses, the ALU SELECT, the operand muxes (immediate vs register, negate for sub) and a one-cycle register write strobe.
- Sits between instruction fetch and the ALU/register-file datapath.

---
 rtl/alu_op_controller.sv | 168 ++++++++++++++++
 tb/tb_alu_op_controller.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_controller.sv
// Multi-cycle control FSM sequencing the 8-bit ALU and 8x8 register file.
// Optional retire counter enabled by defining ALU_CTRL_RETIRE_COUNT_EN.
module alu_op_controller #(
  parameter int unsigned ALU_LATENCY = 2,
  parameter int unsigned OPCODE_W    = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  output logic [2:0]  WRITEREG,
  output logic [7:0]  IMMEDIATE,
  output logic [2:0]  ALU_SELECT,
  output logic        IMM_SEL,
  output logic        NEG_SEL,
  output logic        WRITEENABLE,
  output logic        ILLEGAL,
`ifdef ALU_CTRL_RETIRE_COUNT_EN
  output logic [15:0] RETIRED,
`endif
  output logic        BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LOADI = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_MOV   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(5);

  localparam logic [2:0] SEL_FWD = 3'b000;
  localparam logic [2:0] SEL_ADD = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;

  localparam logic [3:0] WAIT_LOAD = 4'(ALU_LATENCY - 1);

  state_t               state;
  state_t               state_next;
  logic [3:0]           wait_cnt;
  logic [OPCODE_W-1:0]  opcode_q;
  logic [OPCODE_W-1:0]  opcode_in;
  logic                 accept;
  logic                 legal_q;

  logic [2:0]           dec_alu_sel;
  logic                 dec_imm_sel;
  logic                 dec_neg_sel;
  logic                 dec_legal;

  // Register-index fields only use their low three bits.
  logic                 unused_fields;
  assign unused_fields = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

  assign opcode_in = INSTRUCTION[31 -: OPCODE_W];
  assign accept    = (state == S_IDLE) && INSTR_VALID;

  // Decode happens on the incoming word so the datapath controls are
  // already registered and valid during the DECODE cycle.
  always_comb begin
    dec_alu_sel = SEL_FWD;
    dec_imm_sel = 1'b0;
    dec_neg_sel = 1'b0;
    dec_legal   = 1'b1;
    case (opcode_in)
      OP_LOADI: dec_imm_sel = 1'b1;
      OP_MOV:   dec_alu_sel = SEL_FWD;
      OP_ADD:   dec_alu_sel = SEL_ADD;
      OP_SUB: begin
        dec_alu_sel = SEL_ADD;
        dec_neg_sel = 1'b1;
      end
      OP_AND:   dec_alu_sel = SEL_AND;
      OP_OR:    dec_alu_sel = SEL_OR;
      default:  dec_legal   = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_DECODE:  wait_cnt <= WAIT_LOAD;
        S_EXECUTE: if (wait_cnt != '0) wait_cnt <= wait_cnt - 4'd1;
        default:   wait_cnt <= wait_cnt;
      endcase
    end
  end

  // Datapath controls load only on acceptance, so they hold through IDLE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      opcode_q   <= '0;
      legal_q    <= 1'b0;
      READREG1   <= '0;
      READREG2   <= '0;
      WRITEREG   <= '0;
      IMMEDIATE  <= '0;
      ALU_SELECT <= '0;
      IMM_SEL    <= 1'b0;
      NEG_SEL    <= 1'b0;
    end else if (accept) begin
      opcode_q   <= opcode_in;
      legal_q    <= dec_legal;
      READREG1   <= INSTRUCTION[10:8];
      READREG2   <= INSTRUCTION[2:0];
      WRITEREG   <= INSTRUCTION[18:16];
      IMMEDIATE  <= INSTRUCTION[7:0];
      ALU_SELECT <= dec_alu_sel;
      IMM_SEL    <= dec_imm_sel;
      NEG_SEL    <= dec_neg_sel;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (INSTR_VALID) state_next = S_DECODE;
      S_DECODE:    state_next = legal_q ? S_EXECUTE : S_IDLE;
      S_EXECUTE:   if (wait_cnt == '0) state_next = S_WRITEBACK;
      S_WRITEBACK: state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    INSTR_READY = 1'b0;
    BUSY        = 1'b1;
    WRITEENABLE = 1'b0;
    ILLEGAL     = 1'b0;
    case (state)
      S_IDLE: begin
        INSTR_READY = 1'b1;
        BUSY        = 1'b0;
      end
      S_DECODE:    ILLEGAL     = ~legal_q;
      S_WRITEBACK: WRITEENABLE = 1'b1;
      default: ;
    endcase
  end

`ifdef ALU_CTRL_RETIRE_COUNT_EN
  always_ff @(posedge CLK) begin
    if (RESET)
      RETIRED <= '0;
    else if (state == S_WRITEBACK)
      RETIRED <= RETIRED + 16'd1;
  end
`endif

  // opcode_q kept for debug visibility of the instruction in flight.
  logic unused_opcode;
  assign unused_opcode = ^opcode_q;

endmodule

// File: tb/tb_alu_op_controller.sv
// Directed self-checking bench for alu_op_controller (ALU_LATENCY = 2).
module tb_alu_op_controller;

  logic        CLK;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [2:0]  READREG1;
  logic [2:0]  READREG2;
  logic [2:0]  WRITEREG;
  logic [7:0]  IMMEDIATE;
  logic [2:0]  ALU_SELECT;
  logic        IMM_SEL;
  logic        NEG_SEL;
  logic        WRITEENABLE;
  logic        ILLEGAL;
  logic        BUSY;
`ifdef ALU_CTRL_RETIRE_COUNT_EN
  logic [15:0] RETIRED;
`endif

  int tests;
  int fails;

  alu_op_controller #(.ALU_LATENCY(2), .OPCODE_W(8)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTRUCTION (INSTRUCTION),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY),
    .READREG1    (READREG1),
    .READREG2    (READREG2),
    .WRITEREG    (WRITEREG),
    .IMMEDIATE   (IMMEDIATE),
    .ALU_SELECT  (ALU_SELECT),
    .IMM_SEL     (IMM_SEL),
    .NEG_SEL     (NEG_SEL),
    .WRITEENABLE (WRITEENABLE),
    .ILLEGAL     (ILLEGAL),
`ifdef ALU_CTRL_RETIRE_COUNT_EN
    .RETIRED     (RETIRED),
`endif
    .BUSY        (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic test_reset();
    RESET = 1'b1;
    INSTR_VALID = 1'b0;
    INSTRUCTION = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    tests++;
    if ({INSTR_READY, BUSY, WRITEENABLE, ILLEGAL} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_flags: got rdy/busy/we/ill=%b required 1000",
               {INSTR_READY, BUSY, WRITEENABLE, ILLEGAL});
    end
    tests++;
    if ({ALU_SELECT, IMM_SEL, NEG_SEL, WRITEREG, READREG1, READREG2, IMMEDIATE} !== '0) begin
      fails++;
      $display("FAIL reset_fields: got sel=%b imm_sel=%b neg=%b wr=%0d rr1=%0d rr2=%0d imm=%h required all 0",
               ALU_SELECT, IMM_SEL, NEG_SEL, WRITEREG, READREG1, READREG2, IMMEDIATE);
    end
`ifdef ALU_CTRL_RETIRE_COUNT_EN
    tests++;
    if (RETIRED !== 16'd0) begin
      fails++;
      $display("FAIL reset_retired: got %0d required 0", RETIRED);
    end
`endif
  endtask

  task automatic test_loadi();
    @(negedge CLK);
    INSTRUCTION = 32'h00_02_00_5A;
    INSTR_VALID = 1'b1;
    @(posedge CLK);
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      INSTR_VALID = 1'b0;
      if (c == 1) begin
        tests++;
        if ({ALU_SELECT, IMM_SEL, NEG_SEL, WRITEREG, IMMEDIATE} !== {3'b000, 1'b1, 1'b0, 3'd2, 8'h5A}) begin
          fails++;
          $display("FAIL loadi_decode: got sel=%b imm_sel=%b neg=%b wr=%0d imm=%h required 000 1 0 2 5a",
                   ALU_SELECT, IMM_SEL, NEG_SEL, WRITEREG, IMMEDIATE);
        end
      end
      tests++;
      if (WRITEENABLE !== (c == 4)) begin
        fails++;
        $display("FAIL loadi_we c%0d: got %b required %b", c, WRITEENABLE, (c == 4));
      end
      tests++;
      if ({INSTR_READY, BUSY} !== {(c >= 5), (c <= 4)}) begin
        fails++;
        $display("FAIL loadi_ready c%0d: got rdy/busy=%b%b required %b%b",
                 c, INSTR_READY, BUSY, (c >= 5), (c <= 4));
      end
    end
  endtask

  task automatic test_sub();
    @(negedge CLK);
    INSTRUCTION = 32'h03_04_01_02;
    INSTR_VALID = 1'b1;
    @(posedge CLK);
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      INSTR_VALID = 1'b0;
      if (c <= 4) begin
        tests++;
        if ({READREG1, READREG2, ALU_SELECT, NEG_SEL, IMM_SEL, WRITEREG, IMMEDIATE} !==
            {3'd1, 3'd2, 3'b001, 1'b1, 1'b0, 3'd4, 8'h02}) begin
          fails++;
          $display("FAIL sub_fields c%0d: got rr1=%0d rr2=%0d sel=%b neg=%b imm_sel=%b wr=%0d imm=%h required 1 2 001 1 0 4 02",
                   c, READREG1, READREG2, ALU_SELECT, NEG_SEL, IMM_SEL, WRITEREG, IMMEDIATE);
        end
      end
      tests++;
      if (WRITEENABLE !== (c == 4)) begin
        fails++;
        $display("FAIL sub_we c%0d: got %b required %b", c, WRITEENABLE, (c == 4));
      end
    end
  endtask

  task automatic test_illegal();
    @(negedge CLK);
    INSTRUCTION = 32'h7F_01_02_03;
    INSTR_VALID = 1'b1;
    @(posedge CLK);
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      INSTR_VALID = 1'b0;
      tests++;
      if ({ILLEGAL, WRITEENABLE, INSTR_READY, BUSY} !== {(c == 1), 1'b0, (c >= 2), (c == 1)}) begin
        fails++;
        $display("FAIL illegal c%0d: got ill/we/rdy/busy=%b%b%b%b required %b0%b%b",
                 c, ILLEGAL, WRITEENABLE, INSTR_READY, BUSY, (c == 1), (c >= 2), (c == 1));
      end
    end
  endtask

  task automatic test_handshake_reset();
    @(negedge CLK);
    INSTRUCTION = 32'h02_03_01_02;
    INSTR_VALID = 1'b1;
    @(posedge CLK);
    for (int c = 1; c <= 9; c++) begin
      @(negedge CLK);
      if (c == 1) INSTRUCTION = 32'h05_06_04_05;
      if (c <= 4) begin
        tests++;
        if ({INSTR_READY, WRITEREG, ALU_SELECT, WRITEENABLE} !== {1'b0, 3'd3, 3'b001, (c == 4)}) begin
          fails++;
          $display("FAIL hs_busy c%0d: got rdy=%b wr=%0d sel=%b we=%b required 0 3 001 %b",
                   c, INSTR_READY, WRITEREG, ALU_SELECT, WRITEENABLE, (c == 4));
        end
      end else if (c == 5) begin
        tests++;
        if ({INSTR_READY, WRITEREG, ALU_SELECT} !== {1'b1, 3'd3, 3'b001}) begin
          fails++;
          $display("FAIL hs_idle_hold: got rdy=%b wr=%0d sel=%b required 1 3 001",
                   INSTR_READY, WRITEREG, ALU_SELECT);
        end
      end else if (c == 6) begin
        INSTR_VALID = 1'b0;
        tests++;
        if ({BUSY, ALU_SELECT, WRITEREG, READREG1, READREG2} !== {1'b1, 3'b011, 3'd6, 3'd4, 3'd5}) begin
          fails++;
          $display("FAIL hs_second_decode: got busy=%b sel=%b wr=%0d rr1=%0d rr2=%0d required 1 011 6 4 5",
                   BUSY, ALU_SELECT, WRITEREG, READREG1, READREG2);
        end
      end else if (c == 7) begin
        tests++;
        if ({BUSY, WRITEENABLE} !== 2'b10) begin
          fails++;
          $display("FAIL hs_execute: got busy/we=%b%b required 10", BUSY, WRITEENABLE);
        end
        RESET = 1'b1;
      end else if (c == 8) begin
        RESET = 1'b0;
        tests++;
        if ({INSTR_READY, BUSY, WRITEENABLE, ALU_SELECT, WRITEREG} !== {1'b1, 1'b0, 1'b0, 3'b000, 3'd0}) begin
          fails++;
          $display("FAIL hs_abort: got rdy=%b busy=%b we=%b sel=%b wr=%0d required 1 0 0 000 0",
                   INSTR_READY, BUSY, WRITEENABLE, ALU_SELECT, WRITEREG);
        end
`ifdef ALU_CTRL_RETIRE_COUNT_EN
        tests++;
        if (RETIRED !== 16'd0) begin
          fails++;
          $display("FAIL hs_retired: got %0d required 0", RETIRED);
        end
`endif
      end else begin
        tests++;
        if ({WRITEENABLE, BUSY} !== 2'b00) begin
          fails++;
          $display("FAIL hs_after_abort: got we/busy=%b%b required 00", WRITEENABLE, BUSY);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops [3];
    logic [2:0]  exp_sel [3];
    int          we_cyc [3];
    logic [2:0]  sel_seen [3];
    int          n_we;
    int          issued;
    ops[0] = 32'h02_01_02_03; exp_sel[0] = 3'b001;
    ops[1] = 32'h04_02_03_04; exp_sel[1] = 3'b010;
    ops[2] = 32'h05_03_04_05; exp_sel[2] = 3'b011;
    n_we = 0;
    issued = 0;
    for (int i = 0; i < 3; i++) begin
      we_cyc[i] = 0;
      sel_seen[i] = '0;
    end
    for (int c = 0; c < 25; c++) begin
      @(negedge CLK);
      if (WRITEENABLE === 1'b1) begin
        if (n_we < 3) begin
          we_cyc[n_we] = c;
          sel_seen[n_we] = ALU_SELECT;
        end
        n_we++;
      end
      if (INSTR_READY === 1'b1) begin
        if (issued < 3) begin
          INSTRUCTION = ops[issued];
          INSTR_VALID = 1'b1;
          issued++;
        end else begin
          INSTR_VALID = 1'b0;
        end
      end
    end
    INSTR_VALID = 1'b0;
    tests++;
    if (n_we != 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d write pulses required 3", n_we);
    end
    if (n_we >= 3) begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (sel_seen[i] !== exp_sel[i]) begin
          fails++;
          $display("FAIL b2b_sel%0d: got %b required %b", i, sel_seen[i], exp_sel[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        tests++;
        if (we_cyc[i] - we_cyc[i-1] != 5) begin
          fails++;
          $display("FAIL b2b_spacing%0d: got %0d cycles required 5", i, we_cyc[i] - we_cyc[i-1]);
        end
      end
    end
`ifdef ALU_CTRL_RETIRE_COUNT_EN
    tests++;
    if (RETIRED !== 16'd3) begin
      fails++;
      $display("FAIL b2b_retired: got %0d required 3", RETIRED);
    end
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RESET = 1'b1;
    INSTR_VALID = 1'b0;
    INSTRUCTION = '0;
    test_reset();
    test_loadi();
    test_sub();
    test_illegal();
    test_handshake_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
